// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle for mem_bus_arbiter: fetch requester (i_*), data requester (d_*) and the
// shared SRAM-like memory bus.
//   master : arbiter view. Takes requests and bus responses, drives the bus and the
//            requesters' ok/rdata/busy returns.
//   slave  : environment view. Requesters plus memory, the mirror of master.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // Fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_addr_ok;
    logic              i_data_ok;
    logic [31:0]       i_rdata;

    // Data requester
    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wstrb;
    logic [31:0]       d_wdata;
    logic              d_addr_ok;
    logic              d_data_ok;
    logic [31:0]       d_rdata;
    logic              d_busy;

    // Memory bus
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        input  i_req, i_addr,
        output i_addr_ok, i_data_ok, i_rdata,
        input  d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata, d_busy,
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_addr_ok, i_data_ok, i_rdata,
        output d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata, d_busy,
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-to-one arbiter sharing an SRAM-like memory bus between instruction fetch (i_*) and
// the data port (d_*). One transaction is outstanding at a time. Data wins ties, but once
// STARVE_MAX consecutive data grants have been given while fetch is waiting, fetch is
// forced through.
// Ports:
//   clk   : clock, rising edge.
//   reset : asynchronous, active-high.
//   bus   : mem_bus_arbiter_if.master carrying the requester and memory-bus signals.
// Grants (x_addr_ok), completions (x_data_ok) and d_busy are combinational so the
// requesters see them in the cycle the decision is made.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;    // 0 = fetch, 1 = data
    logic [3:0]        streak_q, streak_d;  // data grants given while fetch was waiting
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;

    logic finish;     // owner's data phase completes this cycle
    logic decide;     // a grant may be issued this cycle
    logic starve;
    logic gnt_data;
    logic gnt_fetch;
    logic in_addr;

    always_comb begin
        finish    = (state_q == StData) && bus.data_ok;
        // reset is folded in so no grant leaks out while reset is held
        decide    = !reset && ((state_q == StIdle) || finish);
        starve    = bus.i_req && (streak_q == StarveMax);
        gnt_data  = decide && bus.d_req && !starve;
        gnt_fetch = decide && !gnt_data && bus.i_req;

        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;

        // Spurious addr_ok/data_ok outside their phase fall through untouched.
        case (state_q)
            StIdle:  state_d = StIdle;
            StAddr:  if (bus.addr_ok) state_d = StData;
            StData:  if (bus.data_ok) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A grant overrides the plain transition above, giving back-to-back issue out of DATA.
        if (gnt_data) begin
            state_d  = StAddr;
            owner_d  = 1'b1;
            wr_d     = bus.d_wr;
            size_d   = bus.d_size;
            addr_d   = bus.d_addr;
            wstrb_d  = bus.d_wstrb;
            wdata_d  = bus.d_wdata;
            if (!bus.i_req) begin
                streak_d = 4'd0;
            end else if (streak_q < StarveMax) begin
                streak_d = streak_q + 4'd1;
            end else begin
                streak_d = StarveMax;
            end
        end else if (gnt_fetch) begin
            state_d  = StAddr;
            owner_d  = 1'b0;
            wr_d     = 1'b0;
            size_d   = 2'd2;
            addr_d   = bus.i_addr;
            wstrb_d  = 4'd0;
            wdata_d  = 32'd0;
            streak_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            streak_q <= 4'd0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
        end
    end

    assign in_addr = (state_q == StAddr);

    // Bus command is only presented during the address phase.
    assign bus.req   = in_addr;
    assign bus.wr    = in_addr ? wr_q    : 1'b0;
    assign bus.size  = in_addr ? size_q  : 2'd0;
    assign bus.addr  = in_addr ? addr_q  : '0;
    assign bus.wstrb = in_addr ? wstrb_q : 4'd0;
    assign bus.wdata = in_addr ? wdata_q : 32'd0;

    assign bus.i_addr_ok = gnt_fetch;
    assign bus.d_addr_ok = gnt_data;
    assign bus.i_data_ok = finish && !owner_q;
    assign bus.d_data_ok = finish && owner_q;

    // Read data is broadcast; only the owner's data_ok qualifies it.
    assign bus.i_rdata = bus.rdata;
    assign bus.d_rdata = bus.rdata;

    // Drops in the d_data_ok cycle so the MEM stage can advance on completion.
    assign bus.d_busy = !reset &&
                        (bus.d_req || (owner_q && (state_q != StIdle) && !finish));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW)) bif ();

    mem_bus_arbiter #(
        .STARVE_MAX(4),
        .ADDR_W    (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bif.i_req   = 1'b0;
        bif.i_addr  = '0;
        bif.d_req   = 1'b0;
        bif.d_wr    = 1'b0;
        bif.d_size  = 2'd0;
        bif.d_addr  = '0;
        bif.d_wstrb = 4'd0;
        bif.d_wdata = 32'd0;
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b0;
        bif.rdata   = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bif.i_req = 1'b1;
        bif.d_req = 1'b1;
        #3;
        n_checks++;
        if ({bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata} !== 72'd0)
            $display("FAIL reset_bus: got %h want 0",
                     {bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata});
        else n_pass++;
        n_checks++;
        if ({bif.i_addr_ok, bif.i_data_ok, bif.d_addr_ok, bif.d_data_ok, bif.d_busy} !== 5'b0)
            $display("FAIL reset_oks: got %b want 00000",
                     {bif.i_addr_ok, bif.i_data_ok, bif.d_addr_ok, bif.d_data_ok, bif.d_busy});
        else n_pass++;
        tick();
        bif.i_req = 1'b0;
        bif.d_req = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        n_checks++;
        if ({bif.req, bif.d_busy, bif.d_addr_ok, bif.i_addr_ok} !== 4'b0)
            $display("FAIL reset_release_idle: got %b want 0000",
                     {bif.req, bif.d_busy, bif.d_addr_ok, bif.i_addr_ok});
        else n_pass++;
    endtask

    task automatic test_lone_load();
        tick();
        bif.d_req  = 1'b1;
        bif.d_wr   = 1'b0;
        bif.d_size = 2'd2;
        bif.d_addr = 32'h1000_0004;
        settle();
        n_checks++;
        if ({bif.d_addr_ok, bif.i_addr_ok, bif.req, bif.d_busy} !== 4'b1001)
            $display("FAIL load_grant: got %b want 1001",
                     {bif.d_addr_ok, bif.i_addr_ok, bif.req, bif.d_busy});
        else n_pass++;
        tick();
        bif.d_req   = 1'b0;
        bif.addr_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.wr, bif.size, bif.addr, bif.d_addr_ok, bif.d_busy} !==
            {1'b1, 1'b0, 2'd2, 32'h1000_0004, 1'b0, 1'b1})
            $display("FAIL load_addr_phase: got %h want %h",
                     {bif.req, bif.wr, bif.size, bif.addr, bif.d_addr_ok, bif.d_busy},
                     {1'b1, 1'b0, 2'd2, 32'h1000_0004, 1'b0, 1'b1});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b0;
        settle();
        n_checks++;
        if ({bif.req, bif.d_data_ok, bif.d_busy} !== 3'b001)
            $display("FAIL load_wait: got %b want 001", {bif.req, bif.d_data_ok, bif.d_busy});
        else n_pass++;
        tick();
        bif.data_ok = 1'b1;
        bif.rdata   = 32'hDEAD_BEEF;
        settle();
        n_checks++;
        if ({bif.d_data_ok, bif.i_data_ok, bif.d_busy, bif.d_rdata} !== {3'b100, 32'hDEAD_BEEF})
            $display("FAIL load_done: got %h want %h",
                     {bif.d_data_ok, bif.i_data_ok, bif.d_busy, bif.d_rdata},
                     {3'b100, 32'hDEAD_BEEF});
        else n_pass++;
        tick();
        bif.data_ok = 1'b0;
        settle();
        n_checks++;
        if ({bif.d_busy, bif.req, bif.d_data_ok} !== 3'b000)
            $display("FAIL load_after: got %b want 000", {bif.d_busy, bif.req, bif.d_data_ok});
        else n_pass++;
    endtask

    task automatic test_store();
        tick();
        bif.d_req   = 1'b1;
        bif.d_wr    = 1'b1;
        bif.d_size  = 2'd1;
        bif.d_addr  = 32'h2000_0002;
        bif.d_wstrb = 4'b0011;
        bif.d_wdata = 32'h0000_1234;
        settle();
        n_checks++;
        if (bif.d_addr_ok !== 1'b1)
            $display("FAIL store_grant: got %b want 1", bif.d_addr_ok);
        else n_pass++;
        tick();
        // Scramble the requester fields to show the bus uses the latched copy.
        bif.d_req   = 1'b0;
        bif.d_wr    = 1'b0;
        bif.d_size  = 2'd0;
        bif.d_addr  = 32'hFFFF_FFFF;
        bif.d_wstrb = 4'hF;
        bif.d_wdata = 32'hFFFF_FFFF;
        bif.addr_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata} !==
            {1'b1, 1'b1, 2'd1, 32'h2000_0002, 4'b0011, 32'h0000_1234})
            $display("FAIL store_bus: got %h want %h",
                     {bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata},
                     {1'b1, 1'b1, 2'd1, 32'h2000_0002, 4'b0011, 32'h0000_1234});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b1;
        bif.rdata   = 32'hCAFE_0000;
        settle();
        n_checks++;
        if ({bif.d_data_ok, bif.i_data_ok} !== 2'b10)
            $display("FAIL store_done: got %b want 10", {bif.d_data_ok, bif.i_data_ok});
        else n_pass++;
        tick();
        idle_inputs();
        settle();
        n_checks++;
        if ({bif.i_data_ok, bif.req, bif.d_busy} !== 3'b000)
            $display("FAIL store_after: got %b want 000", {bif.i_data_ok, bif.req, bif.d_busy});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        tick();
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h0000_0100;
        bif.d_req  = 1'b1;
        bif.d_size = 2'd2;
        bif.d_addr = 32'h3000_0000;
        settle();
        n_checks++;
        if ({bif.d_addr_ok, bif.i_addr_ok} !== 2'b10)
            $display("FAIL b2b_first_grant: got %b want 10", {bif.d_addr_ok, bif.i_addr_ok});
        else n_pass++;
        tick();
        bif.d_req   = 1'b0;
        bif.addr_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.addr, bif.i_addr_ok} !== {1'b1, 32'h3000_0000, 1'b0})
            $display("FAIL b2b_d_addr: got %h want %h", {bif.req, bif.addr, bif.i_addr_ok},
                     {1'b1, 32'h3000_0000, 1'b0});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b1;
        bif.rdata   = 32'h1111_1111;
        settle();
        n_checks++;
        if ({bif.d_data_ok, bif.i_data_ok, bif.i_addr_ok, bif.d_addr_ok} !== 4'b1010)
            $display("FAIL b2b_handover: got %b want 1010",
                     {bif.d_data_ok, bif.i_data_ok, bif.i_addr_ok, bif.d_addr_ok});
        else n_pass++;
        tick();
        bif.i_req   = 1'b0;
        bif.data_ok = 1'b0;
        bif.addr_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata} !==
            {1'b1, 1'b0, 2'd2, 32'h0000_0100, 4'd0, 32'd0})
            $display("FAIL b2b_i_addr: got %h want %h",
                     {bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata},
                     {1'b1, 1'b0, 2'd2, 32'h0000_0100, 4'd0, 32'd0});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b1;
        bif.rdata   = 32'h2222_2222;
        settle();
        n_checks++;
        if ({bif.i_data_ok, bif.d_data_ok, bif.i_rdata} !== {2'b10, 32'h2222_2222})
            $display("FAIL b2b_i_done: got %h want %h", {bif.i_data_ok, bif.d_data_ok, bif.i_rdata},
                     {2'b10, 32'h2222_2222});
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_d [6];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tick();
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h0000_0200;
        bif.d_req  = 1'b1;
        bif.d_size = 2'd2;
        bif.d_addr = 32'h4000_0000;
        settle();
        n_checks++;
        if ({bif.d_addr_ok, bif.i_addr_ok} !== {exp_d[0], !exp_d[0]})
            $display("FAIL starve_grant0: got %b want %b", {bif.d_addr_ok, bif.i_addr_ok},
                     {exp_d[0], !exp_d[0]});
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            bif.addr_ok = 1'b1;
            tick();
            bif.addr_ok = 1'b0;
            bif.data_ok = 1'b1;
            if (k == 5) begin
                bif.i_req = 1'b0;
                bif.d_req = 1'b0;
            end
            settle();
            n_checks++;
            if ({bif.d_data_ok, bif.i_data_ok} !== {exp_d[k], !exp_d[k]})
                $display("FAIL starve_done%0d: got %b want %b", k,
                         {bif.d_data_ok, bif.i_data_ok}, {exp_d[k], !exp_d[k]});
            else n_pass++;
            if (k < 5) begin
                n_checks++;
                if ({bif.d_addr_ok, bif.i_addr_ok} !== {exp_d[k+1], !exp_d[k+1]})
                    $display("FAIL starve_grant%0d: got %b want %b", k + 1,
                             {bif.d_addr_ok, bif.i_addr_ok}, {exp_d[k+1], !exp_d[k+1]});
                else n_pass++;
            end else begin
                n_checks++;
                if ({bif.d_addr_ok, bif.i_addr_ok} !== 2'b00)
                    $display("FAIL starve_no_grant: got %b want 00",
                             {bif.d_addr_ok, bif.i_addr_ok});
                else n_pass++;
            end
            tick();
            bif.data_ok = 1'b0;
        end
    endtask

    task automatic test_spurious();
        tick();
        bif.addr_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.i_addr_ok, bif.d_addr_ok, bif.i_data_ok, bif.d_data_ok, bif.d_busy}
            !== 6'b0)
            $display("FAIL spur_addr_ok_idle: got %b want 000000",
                     {bif.req, bif.i_addr_ok, bif.d_addr_ok, bif.i_data_ok, bif.d_data_ok,
                      bif.d_busy});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.i_data_ok, bif.d_data_ok} !== 3'b0)
            $display("FAIL spur_data_ok_idle: got %b want 000",
                     {bif.req, bif.i_data_ok, bif.d_data_ok});
        else n_pass++;
        tick();
        bif.data_ok = 1'b0;
        bif.d_req   = 1'b1;
        bif.d_size  = 2'd2;
        bif.d_addr  = 32'h5000_0000;
        settle();
        n_checks++;
        if (bif.d_addr_ok !== 1'b1)
            $display("FAIL spur_grant: got %b want 1", bif.d_addr_ok);
        else n_pass++;
        tick();
        bif.d_req   = 1'b0;
        bif.data_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.d_data_ok, bif.i_data_ok} !== 3'b100)
            $display("FAIL spur_data_ok_addr: got %b want 100",
                     {bif.req, bif.d_data_ok, bif.i_data_ok});
        else n_pass++;
        tick();
        bif.data_ok = 1'b0;
        settle();
        n_checks++;
        if ({bif.req, bif.addr} !== {1'b1, 32'h5000_0000})
            $display("FAIL spur_still_addr: got %h want %h", {bif.req, bif.addr},
                     {1'b1, 32'h5000_0000});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b1;
        tick();
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.d_data_ok, bif.i_data_ok} !== 2'b10)
            $display("FAIL spur_done: got %b want 10", {bif.d_data_ok, bif.i_data_ok});
        else n_pass++;
        tick();
        bif.data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h0000_0300;
        bif.d_req  = 1'b1;
        bif.d_size = 2'd2;
        bif.d_addr = 32'h6000_0000;
        settle();
        n_checks++;
        if ({bif.d_addr_ok, bif.i_addr_ok} !== 2'b10)
            $display("FAIL rst_pre_grant: got %b want 10", {bif.d_addr_ok, bif.i_addr_ok});
        else n_pass++;
        tick();
        bif.d_req   = 1'b0;
        bif.addr_ok = 1'b1;
        tick();
        bif.addr_ok = 1'b0;
        settle();
        n_checks++;
        if (dut.streak_q !== 4'd1)
            $display("FAIL rst_pre_streak: got %0d want 1", dut.streak_q);
        else n_pass++;
        // Next cycle is the data phase: completion, a new request and reset all arrive together.
        tick();
        bif.data_ok = 1'b1;
        bif.rdata   = 32'h5555_AAAA;
        bif.d_req   = 1'b1;
        bif.d_addr  = 32'h7000_0000;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata} !== 72'd0)
            $display("FAIL rst_mid_bus: got %h want 0",
                     {bif.req, bif.wr, bif.size, bif.addr, bif.wstrb, bif.wdata});
        else n_pass++;
        n_checks++;
        if ({bif.i_addr_ok, bif.i_data_ok, bif.d_addr_ok, bif.d_data_ok, bif.d_busy} !== 5'b0)
            $display("FAIL rst_mid_oks: got %b want 00000",
                     {bif.i_addr_ok, bif.i_data_ok, bif.d_addr_ok, bif.d_data_ok, bif.d_busy});
        else n_pass++;
        tick();
        bif.data_ok = 1'b0;
        bif.i_req   = 1'b0;
        reset       = 1'b0;
        settle();
        n_checks++;
        if ({bif.d_addr_ok, bif.i_addr_ok, dut.streak_q} !== {2'b10, 4'd0})
            $display("FAIL rst_post_grant: got %h want %h", {bif.d_addr_ok, bif.i_addr_ok,
                     dut.streak_q}, {2'b10, 4'd0});
        else n_pass++;
        tick();
        bif.d_req   = 1'b0;
        bif.addr_ok = 1'b1;
        settle();
        n_checks++;
        if ({bif.req, bif.addr} !== {1'b1, 32'h7000_0000})
            $display("FAIL rst_post_addr: got %h want %h", {bif.req, bif.addr},
                     {1'b1, 32'h7000_0000});
        else n_pass++;
        tick();
        bif.addr_ok = 1'b0;
        bif.data_ok = 1'b1;
        bif.rdata   = 32'h0BAD_F00D;
        settle();
        n_checks++;
        if ({bif.d_data_ok, bif.d_rdata} !== {1'b1, 32'h0BAD_F00D})
            $display("FAIL rst_post_done: got %h want %h", {bif.d_data_ok, bif.d_rdata},
                     {1'b1, 32'h0BAD_F00D});
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lone_load();
        test_store();
        test_back_to_back();
        test_starvation();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
